// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the Y86 pipeline control unit: icode constants,
// the "no register" ID, status codes, FSM state type and the control bundle.
// Also carries the project-wide `BYTE / `WORD range macros.

`ifndef PIPE_CTRL_DEFS_SV
`define PIPE_CTRL_DEFS_SV
`define BYTE 7:0
`define WORD 31:0
`endif

package pipe_ctrl_pkg;

    // Y86 instruction codes
    localparam logic [7:0] I_HALT   = 8'h0;
    localparam logic [7:0] I_NOP    = 8'h1;
    localparam logic [7:0] I_RRMOVL = 8'h2;
    localparam logic [7:0] I_IRMOVL = 8'h3;
    localparam logic [7:0] I_RMMOVL = 8'h4;
    localparam logic [7:0] I_MRMOVL = 8'h5;
    localparam logic [7:0] I_OPL    = 8'h6;
    localparam logic [7:0] I_JXX    = 8'h7;
    localparam logic [7:0] I_CALL   = 8'h8;
    localparam logic [7:0] I_RET    = 8'h9;
    localparam logic [7:0] I_PUSHL  = 8'hA;
    localparam logic [7:0] I_POPL   = 8'hB;

    // Register ID meaning "no register"
    localparam logic [7:0] RNONE = 8'hF;

    // Status codes (resized to STAT_W at the point of use)
    localparam int STAT_AOK = 1;
    localparam int STAT_HLT = 2;
    localparam int STAT_ADR = 3;
    localparam int STAT_INS = 4;

    // Run/halt controller states
    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } pipe_state_e;

    // Per-stage control bundle
    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic d_bubble;
        logic e_bubble;
        logic m_bubble;
        logic w_stall;
        logic halted;
    } pipe_ctl_t;

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Combinational hazard detection: load/use, pending return, branch mispredict.

module pipe_hazard
    import pipe_ctrl_pkg::*;
(
    input  logic [`BYTE] D_icode,
    input  logic [`BYTE] d_srcA,
    input  logic [`BYTE] d_srcB,
    input  logic [`BYTE] E_icode,
    input  logic [`BYTE] E_dstM,
    input  logic         e_Cnd,
    input  logic [`BYTE] M_icode,
    output logic         load_use,
    output logic         ret_pend,
    output logic         mispred
);

    // Hazard terms straight from the stage fields; RNONE never matches a source
    always_comb begin
        load_use = ((E_icode == I_MRMOVL) || (E_icode == I_POPL)) &&
                   (E_dstM != RNONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        ret_pend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mispred  = (E_icode == I_JXX) && !e_Cnd;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the five-stage Y86 core.
// Owns the FLUSH/RUN/HALT state machine, the stall/bubble control mux and,
// when PIPE_CTRL_PERF_EN is defined, three saturating performance counters.
// Controls are combinational from the stage inputs and the registered state.
// dbg_state exposes the controller state for observation.

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STAT_W = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [`BYTE]      D_icode,
    input  logic [`BYTE]      d_srcA,
    input  logic [`BYTE]      d_srcB,
    input  logic [`BYTE]      E_icode,
    input  logic [`BYTE]      E_dstM,
    input  logic              e_Cnd,
    input  logic [`BYTE]      M_icode,
    input  logic [STAT_W-1:0] m_stat,
    input  logic [STAT_W-1:0] W_stat,
    output logic              F_stall,
    output logic              D_stall,
    output logic              D_bubble,
    output logic              E_bubble,
    output logic              M_bubble,
    output logic              W_stall,
    output logic              halted,
`ifdef PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0]  perf_cycles,
    output logic [CNT_W-1:0]  perf_stalls,
    output logic [CNT_W-1:0]  perf_bubbles,
`endif
    output pipe_state_e       dbg_state
);

    localparam logic [STAT_W-1:0] AOK = STAT_W'(STAT_AOK);

    logic        load_use;
    logic        ret_pend;
    logic        mispred;
    logic        lu_eff;
    logic        exc_m;
    logic        exc_w;
    pipe_ctl_t   ctl;

    pipe_state_e state_q, state_d;
    logic        flush_cnt_q, flush_cnt_d;

    pipe_hazard u_hazard (
        .D_icode  (D_icode),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .E_icode  (E_icode),
        .E_dstM   (E_dstM),
        .e_Cnd    (e_Cnd),
        .M_icode  (M_icode),
        .load_use (load_use),
        .ret_pend (ret_pend),
        .mispred  (mispred)
    );

    // Exception flags and the load/use term masked by a mispredict
    always_comb begin
        exc_m  = (m_stat != AOK);
        exc_w  = (W_stat != AOK);
        lu_eff = load_use & ~mispred;
    end

    // State register with the FLUSH sequencing bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next state: FLUSH lasts two cycles, RUN halts on a write-back exception
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_FLUSH: begin
                if (flush_cnt_q) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = 1'b0;
                end else begin
                    flush_cnt_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (exc_w) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d     = ST_FLUSH;
                flush_cnt_d = 1'b0;
            end
        endcase
    end

    // Control mux; rst forces the FLUSH pattern even before the first edge
    always_comb begin
        ctl = '0;
        if (rst || (state_q == ST_FLUSH)) begin
            ctl.f_stall  = 1'b1;
            ctl.d_bubble = 1'b1;
            ctl.e_bubble = 1'b1;
            ctl.m_bubble = 1'b1;
        end else if (state_q == ST_HALT || (state_q == ST_RUN && exc_w)) begin
            // Write-back exception freezes the core in the cycle it is seen
            ctl.f_stall  = 1'b1;
            ctl.d_stall  = 1'b1;
            ctl.e_bubble = 1'b1;
            ctl.m_bubble = 1'b1;
            ctl.w_stall  = 1'b1;
            ctl.halted   = (state_q == ST_HALT);
        end else if (state_q == ST_RUN) begin
            ctl.f_stall  = lu_eff | ret_pend;
            ctl.d_stall  = lu_eff;
            ctl.d_bubble = mispred | (ret_pend & ~lu_eff);
            ctl.e_bubble = mispred | lu_eff;
            ctl.m_bubble = exc_m;
        end else begin
            // Unreachable encoding: behave as FLUSH until recovered
            ctl.f_stall  = 1'b1;
            ctl.d_bubble = 1'b1;
            ctl.e_bubble = 1'b1;
            ctl.m_bubble = 1'b1;
        end
    end

    // Drive the output ports from the control bundle
    always_comb begin
        F_stall   = ctl.f_stall;
        D_stall   = ctl.d_stall;
        D_bubble  = ctl.d_bubble;
        E_bubble  = ctl.e_bubble;
        M_bubble  = ctl.m_bubble;
        W_stall   = ctl.w_stall;
        halted    = ctl.halted;
        dbg_state = state_q;
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] cycles_q,  cycles_d;
    logic [CNT_W-1:0] stalls_q,  stalls_d;
    logic [CNT_W-1:0] bubbles_q, bubbles_d;
    logic             run_cyc;

    // Saturating counters that only advance while running
    always_comb begin
        run_cyc   = (state_q == ST_RUN);
        cycles_d  = cycles_q;
        stalls_d  = stalls_q;
        bubbles_d = bubbles_q;
        if (run_cyc && !(&cycles_q)) begin
            cycles_d = cycles_q + CNT_W'(1);
        end
        if (run_cyc && ctl.f_stall && !(&stalls_q)) begin
            stalls_d = stalls_q + CNT_W'(1);
        end
        if (run_cyc && (ctl.d_bubble | ctl.e_bubble) && !(&bubbles_q)) begin
            bubbles_d = bubbles_q + CNT_W'(1);
        end
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_q  <= '0;
            stalls_q  <= '0;
            bubbles_q <= '0;
        end else begin
            cycles_q  <= cycles_d;
            stalls_q  <= stalls_d;
            bubbles_q <= bubbles_d;
        end
    end

    // Counter outputs
    always_comb begin
        perf_cycles  = cycles_q;
        perf_stalls  = stalls_q;
        perf_bubbles = bubbles_q;
    end
`endif

endmodule
